// File: rtl/renas_mem_sched.sv
// Access scheduler for one renas main-memory bank: arbitrates fetch, load/store and
// write-buffer drain onto a single-port SRAM and routes read responses back.
module renas_mem_sched #(
    parameter logic [31:0] BASE_ADDR    = 32'h400,
    parameter int unsigned MEM_WORDS    = 1024,
    parameter int unsigned INST_AGE_MAX = 8,
    localparam int unsigned AW          = $clog2(MEM_WORDS)
) (
    input  logic          mem_clk,
    input  logic          rst_n,
    input  logic          inst_req,
    input  logic [31:0]   inst_addr,
    output logic          inst_gnt,
    output logic          inst_rvalid,
    output logic [31:0]   inst_rdata,
    output logic          inst_err,
    input  logic          data_req,
    input  logic          data_we,
    input  logic [31:0]   data_addr,
    input  logic [31:0]   data_wdata,
    output logic          data_gnt,
    output logic          data_rvalid,
    output logic [31:0]   data_rdata,
    output logic          data_err,
    input  logic          wb_req,
    input  logic [31:0]   wb_addr,
    input  logic [31:0]   wb_wdata,
    input  logic          wb_full,
    output logic          wb_gnt,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int unsigned AGW = $clog2(INST_AGE_MAX + 1);
    localparam logic [AGW-1:0] AGE_MAX = AGW'(INST_AGE_MAX);

    typedef enum logic [1:0] {SrcNone, SrcInst, SrcData, SrcWb} src_e;

    function automatic logic addr_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({2'b00, off[31:2]} >= MEM_WORDS);
    endfunction

    function automatic logic [AW-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[AW+1:2];
    endfunction

    logic           run_q;
    logic [AGW-1:0] inst_age_q, inst_age_d;
    src_e           win;
    logic           inst_el, data_el, wb_el, hazard;
    logic           sel_bad, sel_we;
    logic [31:0]    sel_addr, sel_wdata;
    src_e           tag_src_q, rsp_src_q;
    logic           tag_err_q, tag_rd_q, rsp_err_q, rsp_rd_q;

    // A port whose grant is showing is still holding its old request; mask it.
    assign inst_el = inst_req & ~inst_gnt;
    assign data_el = data_req & ~data_gnt;
    assign wb_el   = wb_req & ~wb_gnt;
    // Once the matching wb has been accepted its write lands before any later read.
    assign hazard  = wb_el & data_req & (wb_addr[31:2] == data_addr[31:2]);

    always_comb begin
        win = SrcNone;
        if (run_q) begin
            if (inst_el && inst_age_q == AGE_MAX) win = SrcInst;
            else if (wb_el && (wb_full || hazard)) win = SrcWb;
            else if (data_el && !hazard)           win = SrcData;
            else if (wb_el)                        win = SrcWb;
            else if (inst_el)                      win = SrcInst;
        end
    end

    always_comb begin
        sel_addr  = inst_addr;
        sel_we    = 1'b0;
        sel_wdata = '0;
        unique case (win)
            SrcData: begin
                sel_addr  = data_addr;
                sel_we    = data_we;
                sel_wdata = data_we ? data_wdata : '0;
            end
            SrcWb: begin
                sel_addr  = wb_addr;
                sel_we    = 1'b1;
                sel_wdata = wb_wdata;
            end
            default: ;
        endcase
        sel_bad = addr_bad(sel_addr);
    end

    always_comb begin
        inst_age_d = inst_age_q;
        if (!inst_req || inst_gnt) begin
            inst_age_d = '0;
        end else if (inst_el && win != SrcInst && inst_age_q != AGE_MAX) begin
            inst_age_d = inst_age_q + 1'b1;
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            inst_age_q <= '0;
            inst_gnt   <= 1'b0;
            data_gnt   <= 1'b0;
            wb_gnt     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            tag_src_q  <= SrcNone;
            tag_err_q  <= 1'b0;
            tag_rd_q   <= 1'b0;
            rsp_src_q  <= SrcNone;
            rsp_err_q  <= 1'b0;
            rsp_rd_q   <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            inst_age_q <= inst_age_d;
            inst_gnt   <= (win == SrcInst);
            data_gnt   <= (win == SrcData);
            wb_gnt     <= (win == SrcWb);
            mem_en     <= (win != SrcNone) && !sel_bad;
            mem_we     <= (win != SrcNone) && !sel_bad && sel_we;
            mem_addr   <= ((win != SrcNone) && !sel_bad) ? addr_idx(sel_addr) : '0;
            mem_wdata  <= ((win != SrcNone) && !sel_bad) ? sel_wdata : '0;
            tag_src_q  <= win;
            tag_err_q  <= (win != SrcNone) && sel_bad;
            tag_rd_q   <= (win == SrcInst || win == SrcData) && !sel_we && !sel_bad;
            rsp_src_q  <= tag_src_q;
            rsp_err_q  <= tag_err_q;
            rsp_rd_q   <= tag_rd_q;
        end
    end

    // SRAM read data arrives the cycle after the command, aligned with the response stage.
    assign inst_rvalid = (rsp_src_q == SrcInst);
    assign inst_err    = inst_rvalid & rsp_err_q;
    assign inst_rdata  = (inst_rvalid && rsp_rd_q) ? mem_rdata : '0;
    assign data_rvalid = (rsp_src_q == SrcData);
    assign data_err    = data_rvalid & rsp_err_q;
    assign data_rdata  = (data_rvalid && rsp_rd_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_renas_mem_sched.sv
// Scoreboard bench for renas_mem_sched with a behavioural single-port SRAM.
module tb_renas_mem_sched;

    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic          mem_clk = 1'b0;
    logic          rst_n;
    logic          inst_req, inst_gnt, inst_rvalid, inst_err;
    logic [31:0]   inst_addr, inst_rdata;
    logic          data_req, data_we, data_gnt, data_rvalid, data_err;
    logic [31:0]   data_addr, data_wdata, data_rdata;
    logic          wb_req, wb_full, wb_gnt;
    logic [31:0]   wb_addr, wb_wdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    logic [31:0]   sram [MEM_WORDS];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t inst_exp[$];
    rsp_t data_exp[$];
    int   n_tests = 0;
    int   n_fail = 0;

    renas_mem_sched dut (
        .mem_clk     (mem_clk),
        .rst_n       (rst_n),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .inst_err    (inst_err),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .data_err    (data_err),
        .wb_req      (wb_req),
        .wb_addr     (wb_addr),
        .wb_wdata    (wb_wdata),
        .wb_full     (wb_full),
        .wb_gnt      (wb_gnt),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 mem_clk = ~mem_clk;

    always @(posedge mem_clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Response scoreboard: every rvalid pops the oldest expectation of its port.
    always @(negedge mem_clk) begin
        rsp_t e;
        if (inst_rvalid) begin
            if (inst_exp.size() == 0) begin
                check("inst_spurious_rvalid", 32'd1, 32'd0);
            end else begin
                e = inst_exp.pop_front();
                check("inst_rdata", inst_rdata, e.rdata);
                check("inst_err", {31'd0, inst_err}, {31'd0, e.err});
            end
        end
        if (data_rvalid) begin
            if (data_exp.size() == 0) begin
                check("data_spurious_rvalid", 32'd1, 32'd0);
            end else begin
                e = data_exp.pop_front();
                check("data_rdata", data_rdata, e.rdata);
                check("data_err", {31'd0, data_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        logic [31:0] bad_addrs [3];
        int cnt;
        for (int i = 0; i < int'(MEM_WORDS); i++) sram[i] = 32'h0;
        sram[1] = 32'hDEADBEEF;
        sram[2] = 32'hCAFE0002;
        rst_n = 1'b0;
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0;
        wb_req = 0; wb_addr = 0; wb_wdata = 0; wb_full = 0;
        #12;
        check("rst_inst_gnt", {31'd0, inst_gnt}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_data_rdata", data_rdata, 32'd0);
        tick();
        rst_n = 1'b1;
        idle(2);

        // Lone fetch
        inst_req = 1; inst_addr = 32'h404;
        inst_exp.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
        tick();
        check("fetch_gnt", {31'd0, inst_gnt}, 32'd1);
        check("fetch_mem_en", {31'd0, mem_en}, 32'd1);
        check("fetch_mem_addr", {22'd0, mem_addr}, 32'd1);
        tick();
        check("fetch_regrant", {31'd0, inst_gnt}, 32'd0);
        check("fetch_rvalid", {31'd0, inst_rvalid}, 32'd1);
        inst_req = 0;
        idle(3);

        // Data and fetch held together alternate
        inst_req = 1; inst_addr = 32'h404;
        data_req = 1; data_we = 0; data_addr = 32'h408;
        for (int i = 0; i < 2; i++) begin
            inst_exp.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
            data_exp.push_back('{rdata: 32'hCAFE0002, err: 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("alt_data_gnt", {31'd0, data_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("alt_inst_gnt", {31'd0, inst_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        inst_req = 0; data_req = 0;
        idle(4);

        // Data and wb saturate the bank; fetch must be promoted by aging
        inst_req = 1; inst_addr = 32'h404;
        data_req = 1; data_we = 0; data_addr = 32'h408;
        wb_req = 1; wb_addr = 32'h600; wb_wdata = 32'h77;
        for (int i = 0; i < 4; i++) data_exp.push_back('{rdata: 32'hCAFE0002, err: 1'b0});
        inst_exp.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!inst_gnt && cnt < 20);
        check("aged_inst_edges", cnt, 32'd9);
        inst_req = 0; data_req = 0; wb_req = 0;
        idle(4);

        // Write-buffer hazard: wb first, data the next cycle sees the new word
        wb_req = 1; wb_addr = 32'h500; wb_wdata = 32'h11;
        data_req = 1; data_we = 0; data_addr = 32'h500;
        data_exp.push_back('{rdata: 32'h11, err: 1'b0});
        tick();
        check("haz_wb_gnt", {31'd0, wb_gnt}, 32'd1);
        check("haz_data_early", {31'd0, data_gnt}, 32'd0);
        check("haz_mem_we", {31'd0, mem_we}, 32'd1);
        check("haz_mem_addr", {22'd0, mem_addr}, 32'h40);
        check("haz_mem_wdata", mem_wdata, 32'h11);
        tick();
        check("haz_data_gnt", {31'd0, data_gnt}, 32'd1);
        check("haz_wb_regrant", {31'd0, wb_gnt}, 32'd0);
        wb_req = 0; data_req = 0;
        idle(3);

        // Store completes with zero data, load returns it
        data_req = 1; data_we = 1; data_addr = 32'h504; data_wdata = 32'h22;
        data_exp.push_back('{rdata: 32'h0, err: 1'b0});
        tick();
        check("st_mem_we", {31'd0, mem_we}, 32'd1);
        tick();
        data_we = 0;
        data_exp.push_back('{rdata: 32'h22, err: 1'b0});
        tick();
        check("ld_after_st_gnt", {31'd0, data_gnt}, 32'd1);
        data_req = 0;
        idle(3);

        // Bad data addresses
        bad_addrs[0] = 32'h3FC;
        bad_addrs[1] = 32'h402;
        bad_addrs[2] = 32'h400 + 4 * MEM_WORDS;
        for (int i = 0; i < 3; i++) begin
            data_req = 1; data_we = 0; data_addr = bad_addrs[i];
            data_exp.push_back('{rdata: 32'h0, err: 1'b1});
            tick();
            check("bad_data_gnt", {31'd0, data_gnt}, 32'd1);
            check("bad_data_mem_en", {31'd0, mem_en}, 32'd0);
            data_req = 0;
            idle(2);
        end

        // Bad wb address is accepted and dropped
        wb_req = 1; wb_addr = 32'h3F0; wb_wdata = 32'h99;
        tick();
        check("bad_wb_gnt", {31'd0, wb_gnt}, 32'd1);
        check("bad_wb_mem_en", {31'd0, mem_en}, 32'd0);
        wb_req = 0;
        idle(2);

        // Full write buffer jumps ahead of a non-conflicting load
        wb_req = 1; wb_full = 1; wb_addr = 32'h600; wb_wdata = 32'h55;
        data_req = 1; data_we = 0; data_addr = 32'h408;
        data_exp.push_back('{rdata: 32'hCAFE0002, err: 1'b0});
        tick();
        check("full_wb_gnt", {31'd0, wb_gnt}, 32'd1);
        check("full_data_early", {31'd0, data_gnt}, 32'd0);
        tick();
        check("full_data_gnt", {31'd0, data_gnt}, 32'd1);
        wb_req = 0; wb_full = 0; data_req = 0;
        idle(3);

        // Reset right after a grant drops the pending response
        inst_req = 1; inst_addr = 32'h404;
        tick();
        check("prerst_gnt", {31'd0, inst_gnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("inrst_inst_gnt", {31'd0, inst_gnt}, 32'd0);
        check("inrst_mem_en", {31'd0, mem_en}, 32'd0);
        check("inrst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("inrst_inst_rvalid", {31'd0, inst_rvalid}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        inst_exp.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
        tick();
        check("postrst_first_edge", {31'd0, inst_gnt}, 32'd0);
        tick();
        check("postrst_second_edge", {31'd0, inst_gnt}, 32'd1);
        inst_req = 0;
        idle(5);

        check("inst_pending", inst_exp.size(), 32'd0);
        check("data_pending", data_exp.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
